// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and default FIFO depth shared by uart_tx_fifo and its bench
package uart_pkg;
  localparam int DEPTH_LOG2_DEFAULT = 4;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port byte RAM (clk, we/waddr/wdata sync write, raddr/rdata async read)
module uart_fifo_mem #(
  parameter int AW = 4
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [7:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO (WrData/WrEn in; Full/Empty/Level out) drained to a UART transmitter via TxData/TxSend/TxBusy handshake; sticky Overflow port only with UART_TX_FIFO_OVERFLOW_EN
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input logic Clk,
  input logic Reset,
  input logic [7:0] WrData,
  input logic WrEn,
  output logic Full,
  output logic Empty,
  output logic [DEPTH_LOG2:0] Level,
  output logic [7:0] TxData,
  output logic TxSend,
  input logic TxBusy
`ifdef UART_TX_FIFO_OVERFLOW_EN
  , output logic Overflow
`endif
);
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [1:0] state;
  logic [7:0] head;
  logic wr, pop;
  logic [DEPTH_LOG2:0] level_nxt;
  assign wr = WrEn & ~Full;
  assign pop = (state == IDLE) & ~Empty & ~TxBusy;
  assign level_nxt = Level + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
  uart_fifo_mem #(.AW(DEPTH_LOG2)) u_mem (
    .clk(Clk),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(WrData),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Level <= '0;
      Empty <= 1'b1;
      Full <= 1'b0;
      TxSend <= 1'b0;
      TxData <= 8'h00;
      state <= IDLE;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        TxData <= head;
        TxSend <= 1'b1;
        state <= REQ;
      end else if (state == REQ && TxBusy) begin
        TxSend <= 1'b0;
        state <= WAIT;
      end else if (state == WAIT && !TxBusy) begin
        state <= IDLE;
      end
      Level <= level_nxt;
      Full <= level_nxt[DEPTH_LOG2];
      Empty <= level_nxt == '0;
    end
  end
`ifdef UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge Clk) Overflow <= Reset ? 1'b0 : Overflow | (WrEn & Full);
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a transmitter model and randomized traffic
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic WrEn = 1'b0;
  logic [7:0] WrData = 8'h00;
  logic Full, Empty, TxSend, TxBusy;
  logic [4:0] Level;
  logic [7:0] TxData;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic Overflow;
  logic ovf_m = 1'b0;
`endif
  int vectors = 0;
  int miscompares = 0;
  int busy_mode = 0;
  int sends = 0;
  int tcnt = 0;
  logic mdl_busy = 1'b0;
  logic busy_at_edge = 1'b0;
  logic prev_send = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_q[$];

  uart_tx_fifo dut (
    .Clk(Clk),
    .Reset(Reset),
    .WrData(WrData),
    .WrEn(WrEn),
    .Full(Full),
    .Empty(Empty),
    .Level(Level),
    .TxData(TxData),
    .TxSend(TxSend),
    .TxBusy(TxBusy)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    , .Overflow(Overflow)
`endif
  );

  always #5 Clk = ~Clk;

  assign TxBusy = busy_mode == 1 ? 1'b1 : busy_mode == 2 ? 1'b0 : mdl_busy;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  always @(posedge Clk)
    if (Reset) begin
      mdl_busy <= 1'b0;
      tcnt <= 0;
    end else if (tcnt == 0) begin
      if (TxSend && !mdl_busy) tcnt <= 1;
    end else if (tcnt == 1) begin
      mdl_busy <= 1'b1;
      tcnt <= 2;
    end else if (tcnt == 11) begin
      mdl_busy <= 1'b0;
      tcnt <= 0;
    end else tcnt <= tcnt + 1;

  always begin
    @(posedge Clk);
    busy_at_edge = TxBusy;
    if (Reset) begin
      exp_q.delete();
`ifdef UART_TX_FIFO_OVERFLOW_EN
      ovf_m = 1'b0;
`endif
    end else if (WrEn) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(WrData);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      else ovf_m = 1'b1;
`endif
    end
    @(negedge Clk);
    if (TxSend && !prev_send) begin
      sends++;
      chk("send_while_busy", busy_at_edge, 0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_send: TxData=%0h with nothing queued", TxData);
      end else chk("tx_order", TxData, exp_q.pop_front());
    end else if (TxSend) chk("txdata_hold", TxData, prev_data);
    chk("level", Level, exp_q.size());
    chk("full", Full, exp_q.size() == DEPTH);
    chk("empty", Empty, exp_q.size() == 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("overflow", Overflow, ovf_m);
`endif
    prev_send = TxSend;
    prev_data = TxData;
  end

  task automatic tick;
    @(negedge Clk);
  endtask

  task automatic wr(input logic [7:0] d);
    WrEn = 1'b1;
    WrData = d;
    tick();
    WrEn = 1'b0;
  endtask

  task automatic drain;
    int i;
    for (i = 0; i < 3000 && !(exp_q.size() == 0 && !TxSend && !TxBusy && Empty); i++) tick();
    chk("drain_done", i < 3000, 1);
    repeat (2) tick();
  endtask

  initial begin
    int n, s;
    repeat (3) tick();
    chk("rst_level", Level, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_send", TxSend, 0);
    chk("rst_data", TxData, 8'h00);
    Reset = 1'b0;
    WrEn = 1'b1;
    WrData = 8'hA5;
    tick();
    WrEn = 1'b0;
    chk("s1_level_after_write", Level, 1);
    chk("s1_send_not_yet", TxSend, 0);
    tick();
    chk("s1_send", TxSend, 1);
    chk("s1_data", TxData, 8'hA5);
    chk("s1_level_popped", Level, 0);
    for (int i = 0; i < 10 && !TxBusy; i++) tick();
    chk("s1_busy_seen", TxBusy, 1);
    tick();
    chk("s1_send_drop", TxSend, 0);
    drain();
    busy_mode = 1;
    for (int i = 0; i < 16; i++) wr(i[7:0]);
    chk("s2_full", Full, 1);
    chk("s2_level16", Level, 16);
    wr(8'hFF);
    chk("s2_drop_level", Level, 16);
    chk("s2_drop_full", Full, 1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    chk("s2_overflow", Overflow, 1);
`endif
    busy_mode = 0;
    drain();
    busy_mode = 1;
    wr(8'h31);
    wr(8'h32);
    wr(8'h33);
    chk("s3_level3", Level, 3);
    WrEn = 1'b1;
    WrData = 8'h34;
    busy_mode = 2;
    tick();
    WrEn = 1'b0;
    chk("s3_level_same", Level, 3);
    chk("s3_popped", TxSend, 1);
    busy_mode = 0;
    drain();
    n = 0;
    for (int i = 0; i < 5000 && n < 40; i++)
      if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        wr(8'($urandom));
        n++;
      end else tick();
    chk("s4_all_written", n, 40);
    drain();
    chk("s4_empty", Empty, 1);
    busy_mode = 2;
    for (int i = 0; i < 6; i++) wr(8'h50 + i[7:0]);
    repeat (50) tick();
    chk("s6_level_held", Level, 5);
    chk("s6_send_held", TxSend, 1);
    chk("s6_data_held", TxData, 8'h50);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("s5_send_cleared", TxSend, 0);
    chk("s5_level_cleared", Level, 0);
    chk("s5_empty", Empty, 1);
    chk("s5_full", Full, 0);
    busy_mode = 0;
    s = sends;
    repeat (40) tick();
    chk("s5_no_stale_send", sends - s, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, 4, log2 of FIFO depth (16 bytes).
REQ-002 SHALL have port: Clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: WrData  input  8  byte to queue.
REQ-005 SHALL have port: WrEn  input  1  one-cycle write strobe for WrData.
REQ-006 SHALL have port: Full  output  1  high when Level equals 2^DEPTH_LOG2.
REQ-007 SHALL have port: Empty  output  1  high when Level equals 0.
REQ-008 SHALL have port: Level  output  DEPTH_LOG2+1  bytes currently stored.
REQ-009 SHALL have port: TxData  output  8  byte presented to the downstream UART transmitter.
REQ-010 SHALL have port: TxSend  output  1  send request to the transmitter.
REQ-011 SHALL have port: TxBusy  input  1  transmitter busy flag.
REQ-012 SHALL have port, with UART_TX_FIFO_OVERFLOW_EN only: Overflow  output  1  sticky dropped-write flag.

Function
REQ-013 SHALL store bytes in a circular buffer of 2^DEPTH_LOG2 entries, with read/write pointers of DEPTH_LOG2 bits that wrap modulo depth.
REQ-014 SHALL accept a write when WrEn=1 and Full=0 (registered value); the byte is stored and available to the drain FSM the next cycle.
REQ-015 SHALL ignore a write when Full=1, even if a pop occurs in the same cycle.
REQ-016 SHALL update Level as +1 on write only, -1 on pop only, and unchanged on simultaneous write and pop.
REQ-017 SHALL register Full, Empty and Level, and SHALL keep them consistent with Level in the same cycle.
REQ-018 SHALL drain the FIFO with FSM states IDLE, REQ and WAIT.
REQ-019 SHALL, in IDLE with Empty=0: load TxData from the head, advance the read pointer (pop), set TxSend=1, and go to REQ.
REQ-020 SHALL, in REQ: hold TxSend=1 and TxData stable until TxBusy=1 is sampled, then set TxSend=0 and go to WAIT.
REQ-021 SHALL, in WAIT: hold TxSend=0 until TxBusy=0 is sampled, then go to IDLE.
REQ-022 SHALL treat the transmitter's 2-cycle Send-to-Busy latency as normal, with no timeout in REQ.
REQ-023 SHALL never assert TxSend while TxBusy=1 in IDLE.
REQ-024 SHALL give back-to-back bytes a minimum spacing of one IDLE cycle after TxBusy falls.
REQ-025 SHALL keep TxData unchanged outside REQ-019 loads.

Reset
REQ-026 SHALL, while Reset=1: clear both pointers, Level=0, Empty=1, Full=0, TxSend=0, TxData=8'h00, FSM to IDLE, and Overflow=0.
REQ-027 SHALL, on reset mid-transfer, discard all queued bytes and the in-flight request; Reset is shared with the transmitter.
REQ-028 SHALL leave FIFO memory contents uninitialised; they are unobservable.

Configuration
REQ-029 SHALL support macro UART_TX_FIFO_OVERFLOW_EN.
REQ-030 SHALL, with UART_TX_FIFO_OVERFLOW_EN defined: set Overflow=1 on any write attempt while Full=1; Overflow is cleared only by Reset.
REQ-031 SHALL, without UART_TX_FIFO_OVERFLOW_EN: omit the Overflow port and its logic; dropped writes are silent.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE=2'b00, REQ=2'b01, WAIT=2'b10) and the default DEPTH_LOG2 in shared package uart_pkg.
REQ-033 SHALL use one sub-module, uart_fifo_mem: a simple dual-port 8-bit RAM with synchronous write and asynchronous read; pointers and flags live in the top.

Verification
REQ-034 SHALL cover: single write 8'hA5 with a transmitter model (Busy rises 2 cycles after Send, stays high 10 cycles) -> TxSend high 1 cycle after the write, TxData=8'hA5, TxSend falls the cycle after Busy is seen, Level back to 0.
REQ-035 SHALL cover: 16 consecutive writes 8'h00..8'h0F with TxBusy held high -> Full=1 after the 16th, Level=16, and a 17th write 8'hFF is dropped (Overflow=1 if enabled); output order is 00..0F.
REQ-036 SHALL cover: simultaneous WrEn and pop at Level=3 -> Level stays 3 and ordering is preserved.
REQ-037 SHALL cover: pointer wrap by writing and draining 40 bytes -> every byte emitted in order, with Empty=1 at the end.
REQ-038 SHALL cover: Reset asserted in REQ with Level=5 -> next cycle TxSend=0, Level=0, Empty=1, FSM IDLE, and no stale byte sent afterwards.
REQ-039 SHALL cover: TxBusy stuck low for 50 cycles in REQ -> TxSend and TxData held stable with no pop.
